// File: rtl/led_fade_seq_if.sv
// led_fade_seq_if: register-bank <-> fade sequencer control and duty bus.
// Carries the breathe request only when FADE_BREATHE_EN is defined.
interface led_fade_seq_if #(
    parameter int DW   = 8,
    parameter int DIVW = 16
);
    logic            ena;
    logic            start;
    logic [DW-1:0]   tgt_red;
    logic [DW-1:0]   tgt_green;
    logic [DW-1:0]   tgt_blue;
    logic [DIVW-1:0] step_div;
    logic [DW-1:0]   step_size;
    logic [DW-1:0]   duty_red;
    logic [DW-1:0]   duty_green;
    logic [DW-1:0]   duty_blue;
    logic            busy;
    logic            done;
`ifdef FADE_BREATHE_EN
    logic            breathe;
`endif
    modport master (
`ifdef FADE_BREATHE_EN
        output breathe,
`endif
        output ena, start, tgt_red, tgt_green, tgt_blue, step_div, step_size,
        input  duty_red, duty_green, duty_blue, busy, done
    );
    modport slave (
`ifdef FADE_BREATHE_EN
        input  breathe,
`endif
        input  ena, start, tgt_red, tgt_green, tgt_blue, step_div, step_size,
        output duty_red, duty_green, duty_blue, busy, done
    );
endinterface

// File: rtl/led_fade_seq.sv
// led_fade_seq: ramps RGB duty words toward latched targets at a prescaled step rate, pulses done.
// Optional FADE_BREATHE_EN: with breathe=1 the ramp bounces between the targets and 0 instead of finishing.
module led_fade_seq #(
    parameter int DW   = 8,
    parameter int DIVW = 16
) (
    input logic            clk,
    input logic            resetb,
    led_fade_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;
    state_t          r_state, w_state;
    logic [DIVW-1:0] r_cnt, w_cnt;
    logic [DW-1:0]   r_tgt [3];
    logic [DW-1:0]   w_tgt [3];
    logic [DW-1:0]   r_duty [3];
    logic [DW-1:0]   w_duty [3];
    logic [DW-1:0]   w_in [3];
    logic [DW-1:0]   w_goal [3];
    logic [DW-1:0]   w_step [3];
    logic [DW-1:0]   w_ss;
    logic            r_down, w_down, w_at_goal, w_breathe;

    // Clamp the move to the remaining distance so a step never overshoots or wraps.
    function automatic logic [DW-1:0] step_to(input logic [DW-1:0] cur, input logic [DW-1:0] goal,
                                              input logic [DW-1:0] ss);
        logic [DW-1:0] diff;
        diff = (goal > cur) ? goal - cur : cur - goal;
        if (diff > ss) diff = ss;
        return (goal > cur) ? cur + diff : cur - diff;
    endfunction

`ifdef FADE_BREATHE_EN
    assign w_breathe = bus.breathe;
`else
    assign w_breathe = 1'b0;
`endif

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_down    = r_down;
        w_tgt     = r_tgt;
        w_duty    = r_duty;
        w_ss      = (bus.step_size == '0) ? DW'(1) : bus.step_size;
        w_in      = '{bus.tgt_red, bus.tgt_green, bus.tgt_blue};
        w_at_goal = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w_goal[k] = r_down ? '0 : r_tgt[k];
            w_step[k] = step_to(r_duty[k], w_goal[k], w_ss);
            if (w_step[k] != w_goal[k]) w_at_goal = 1'b0;
        end
        if (bus.ena) begin
            if (bus.start) begin
                w_tgt   = w_in;
                w_cnt   = bus.step_div;
                w_down  = 1'b0;
                w_state = RAMP;
            end else if (r_state == RAMP) begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                end else begin
                    w_cnt  = bus.step_div;
                    w_duty = w_step;
                    if (w_at_goal) begin
                        if (w_breathe) w_down = !r_down;
                        else           w_state = DONE;
                    end
                end
            end else if (r_state == DONE) begin
                w_state = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_down  <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_tgt[k]  <= '0;
                r_duty[k] <= '0;
            end
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_down  <= w_down;
            r_tgt   <= w_tgt;
            r_duty  <= w_duty;
        end
    end

    assign bus.duty_red   = r_duty[0];
    assign bus.duty_green = r_duty[1];
    assign bus.duty_blue  = r_duty[2];
    assign bus.busy       = (r_state == RAMP);
    assign bus.done       = (r_state == DONE);
endmodule

// File: tb/tb_led_fade_seq.sv
// tb_led_fade_seq: directed checks of led_fade_seq ramps, prescaling, retarget, freeze and reset.
// Breathe checks are included when FADE_BREATHE_EN is defined.
module tb_led_fade_seq;
    logic clk = 1'b0;
    logic resetb;
    int   n_chk = 0;
    int   n_err = 0;

    led_fade_seq_if #(.DW(8), .DIVW(16)) bus ();
    led_fade_seq #(.DW(8), .DIVW(16)) dut (.clk(clk), .resetb(resetb), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [7:0] sz, input logic [15:0] dv);
        bus.tgt_red   = r;
        bus.tgt_green = g;
        bus.tgt_blue  = b;
        bus.step_size = sz;
        bus.step_div  = dv;
        bus.start     = 1'b1;
        tick(1);
        bus.start     = 1'b0;
    endtask

    task automatic rst_pulse();
        resetb = 1'b0;
        tick(1);
        resetb = 1'b1;
    endtask

    initial begin
        resetb        = 1'b0;
        bus.ena       = 1'b1;
        bus.start     = 1'b0;
        bus.tgt_red   = '0;
        bus.tgt_green = '0;
        bus.tgt_blue  = '0;
        bus.step_div  = '0;
        bus.step_size = '0;
`ifdef FADE_BREATHE_EN
        bus.breathe   = 1'b0;
`endif
        // Reset and idle hold
        tick(3);
        chk("rst_red", bus.duty_red, 0);
        chk("rst_green", bus.duty_green, 0);
        chk("rst_blue", bus.duty_blue, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        resetb = 1'b1;
        tick(2);
        chk("idle_red", bus.duty_red, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        // Linear ramp, one step per cycle
        go(8'h10, 8'h00, 8'h00, 8'h04, 16'd0);
        chk("lin_busy0", bus.busy, 1);
        chk("lin_red0", bus.duty_red, 8'h00);
        tick(1); chk("lin_red1", bus.duty_red, 8'h04);
        tick(1); chk("lin_red2", bus.duty_red, 8'h08);
        tick(1); chk("lin_red3", bus.duty_red, 8'h0C);
        chk("lin_done3", bus.done, 0);
        tick(1); chk("lin_red4", bus.duty_red, 8'h10);
        chk("lin_done4", bus.done, 1);
        chk("lin_busy4", bus.busy, 0);
        tick(1); chk("lin_done5", bus.done, 0);
        chk("lin_busy5", bus.busy, 0);
        // Clamp and prescale
        rst_pulse();
        go(8'h50, 8'h00, 8'h00, 8'h30, 16'd3);
        tick(3); chk("clp_red_pre", bus.duty_red, 8'h00);
        chk("clp_busy", bus.busy, 1);
        tick(1); chk("clp_red1", bus.duty_red, 8'h30);
        tick(3); chk("clp_red_hold", bus.duty_red, 8'h30);
        tick(1); chk("clp_red2", bus.duty_red, 8'h50);
        chk("clp_done", bus.done, 1);
        tick(1); chk("clp_done_end", bus.done, 0);
        chk("clp_red_end", bus.duty_red, 8'h50);
        // Downward ramp with retarget
        go(8'hF0, 8'h00, 8'h00, 8'hA0, 16'd0);
        tick(1); chk("dn_setup", bus.duty_red, 8'hF0);
        go(8'h00, 8'h00, 8'h00, 8'h10, 16'd0);
        chk("dn_start", bus.duty_red, 8'hF0);
        tick(5); chk("dn_red_a0", bus.duty_red, 8'hA0);
        chk("dn_done_a0", bus.done, 0);
        go(8'h80, 8'h00, 8'h00, 8'h10, 16'd0);
        chk("rt_hold", bus.duty_red, 8'hA0);
        chk("rt_busy", bus.busy, 1);
        tick(1); chk("rt_red90", bus.duty_red, 8'h90);
        chk("rt_done90", bus.done, 0);
        tick(1); chk("rt_red80", bus.duty_red, 8'h80);
        chk("rt_done80", bus.done, 1);
        tick(1); chk("rt_done_end", bus.done, 0);
        chk("rt_red_end", bus.duty_red, 8'h80);
        // Freeze with ignored start, then reset mid-ramp
        rst_pulse();
        go(8'h40, 8'h00, 8'h00, 8'h10, 16'd0);
        tick(2); chk("frz_pre", bus.duty_red, 8'h20);
        bus.ena = 1'b0;
        bus.tgt_red = 8'hFF;
        bus.start = 1'b1;
        tick(5); chk("frz_red", bus.duty_red, 8'h20);
        chk("frz_busy", bus.busy, 1);
        bus.start = 1'b0;
        bus.ena = 1'b1;
        tick(1); chk("frz_red30", bus.duty_red, 8'h30);
        tick(1); chk("frz_red40", bus.duty_red, 8'h40);
        chk("frz_done", bus.done, 1);
        go(8'h80, 8'h00, 8'h00, 8'h10, 16'd0);
        tick(1); chk("mid_red50", bus.duty_red, 8'h50);
        resetb = 1'b0;
        tick(1); chk("mid_rst_red", bus.duty_red, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        resetb = 1'b1;
        tick(1); chk("mid_idle_busy", bus.busy, 0);
        // All three channels must arrive before done
        go(8'h04, 8'h08, 8'h0C, 8'h04, 16'd0);
        tick(1); chk("mc1_g", bus.duty_green, 8'h04);
        chk("mc1_b", bus.duty_blue, 8'h04);
        chk("mc1_done", bus.done, 0);
        tick(1); chk("mc2_r", bus.duty_red, 8'h04);
        chk("mc2_g", bus.duty_green, 8'h08);
        chk("mc2_b", bus.duty_blue, 8'h08);
        chk("mc2_done", bus.done, 0);
        tick(1); chk("mc3_b", bus.duty_blue, 8'h0C);
        chk("mc3_done", bus.done, 1);
        // step_size 0 behaves as 1
        go(8'h04, 8'h08, 8'h0E, 8'h00, 16'd0);
        tick(1); chk("z1_b", bus.duty_blue, 8'h0D);
        chk("z1_done", bus.done, 0);
        tick(1); chk("z2_b", bus.duty_blue, 8'h0E);
        chk("z2_done", bus.done, 1);
        // Targets already reached: one step period, then done
        go(8'h04, 8'h08, 8'h0E, 8'h05, 16'd2);
        tick(2); chk("eq_busy", bus.busy, 1);
        chk("eq_done_pre", bus.done, 0);
        tick(1); chk("eq_done", bus.done, 1);
        chk("eq_red", bus.duty_red, 8'h04);
`ifdef FADE_BREATHE_EN
        rst_pulse();
        bus.breathe = 1'b1;
        go(8'h00, 8'h00, 8'h08, 8'h08, 16'd0);
        tick(1); chk("br_b1", bus.duty_blue, 8'h08);
        chk("br_done1", bus.done, 0);
        tick(1); chk("br_b2", bus.duty_blue, 8'h00);
        chk("br_busy2", bus.busy, 1);
        tick(1); chk("br_b3", bus.duty_blue, 8'h08);
        tick(1); chk("br_b4", bus.duty_blue, 8'h00);
        chk("br_done4", bus.done, 0);
        bus.breathe = 1'b0;
        tick(1); chk("br_b5", bus.duty_blue, 8'h08);
        chk("br_done5", bus.done, 1);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
